// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: snoops register-file writes into a FIFO, freezes on stop.
// Optional macro TRACE_WRAP_EN: overwrite the oldest entry when full instead of dropping the newest.
module wb_trace_buffer #(
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          arm,
    input  logic          stop,
    input  logic          rf_write,
    input  logic [1:0]    regw,
    input  logic [7:0]    dataw,
    input  logic          pop,
    output logic          out_valid,
    output logic [1:0]    out_reg,
    output logic [7:0]    out_data,
    output logic [7:0]    out_seq,
    output logic [AW:0]   count,
    output logic          full,
    output logic          overflow,
    output logic [7:0]    drop_count,
    output logic [1:0]    state
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] L_DEPTH = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [17:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_next;
    logic [7:0]       r_seq;
    logic             r_overflow;
    logic [7:0]       r_drop;
    logic             w_full;
    logic             w_cap;
    logic             w_pop_ok;
    logic             w_lost;
    logic             w_store;
    logic             w_rd_adv;
    logic [17:0]      w_head;

    assign w_full   = (r_count == L_DEPTH);
    assign w_cap    = (r_state == ST_CAPTURE) && rf_write && !arm;
    assign w_pop_ok = pop && (r_count != '0) && !arm;
    assign w_lost   = w_cap && w_full && !w_pop_ok;

`ifdef TRACE_WRAP_EN
    // A lost write overwrites the head slot, so the read pointer moves past it.
    assign w_store  = w_cap;
    assign w_rd_adv = w_pop_ok || w_lost;
`else
    assign w_store  = w_cap && (!w_full || w_pop_ok);
    assign w_rd_adv = w_pop_ok;
`endif

    always_comb begin
        w_count_next = r_count;
        if (w_store && !w_rd_adv)
            w_count_next = r_count + (AW+1)'(1);
        else if (!w_store && w_rd_adv)
            w_count_next = r_count - (AW+1)'(1);
    end

    always_comb begin
        w_state_next = r_state;
        if (arm)
            w_state_next = ST_CAPTURE;
        else if (r_state == ST_CAPTURE && stop)
            w_state_next = ST_FROZEN;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (arm) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else begin
            if (w_store)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_adv)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            // Every observed write consumes a sequence number, stored or not.
            if (w_cap)
                r_seq <= r_seq + 8'd1;
            if (w_lost) begin
                r_overflow <= 1'b1;
                r_drop     <= sat_inc8(r_drop);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_store) begin
            r_mem[r_wr_ptr] <= {r_seq, regw, dataw};
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign out_valid  = (r_count != '0);
    assign out_seq    = w_head[17:10];
    assign out_reg    = w_head[9:8];
    assign out_data   = w_head[7:0];
    assign count      = r_count;
    assign full       = w_full;
    assign overflow   = r_overflow;
    assign drop_count = r_drop;
    assign state      = r_state;

endmodule
